// File: rtl/ibuf_pkg.sv
// Shared types and sizing for the fetch-to-ctrlblock instruction buffer.
package ibuf_pkg;

    localparam int unsigned IBUF_DEPTH  = 8;
    localparam int unsigned IBUF_INST_W = 32;
    localparam int unsigned IBUF_PC_W   = 48;
    localparam int unsigned IBUF_IDX_W  = $clog2(IBUF_DEPTH);
    localparam int unsigned IBUF_PTR_W  = IBUF_IDX_W + 1;

    // One queued fetch result
    typedef struct packed {
        logic [IBUF_INST_W-1:0] inst;
        logic [IBUF_PC_W-1:0]   pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuffer_ptr.sv
// Wrap-bit circular pointer: index in the low bits, wrap flag in the MSB.
// A plain binary increment gives index wrap DEPTH-1 -> 0 with a wrap-bit
// toggle because DEPTH is a power of two.
module ibuffer_ptr #(
    parameter int unsigned PTR_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Pointer register; clear wins over increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ibuffer.sv
// Instruction buffer between fetch and ctrlblock: strict FIFO of {inst, pc}
// with valid/ready on both sides, emptied by a synchronous flush.
module ibuffer
    import ibuf_pkg::*;
#(
    parameter int unsigned DEPTH      = IBUF_DEPTH,
    parameter int unsigned INST_WIDTH = IBUF_INST_W,
    parameter int unsigned PC_WIDTH   = IBUF_PC_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [INST_WIDTH-1:0]   fetch_inst,
    input  logic [PC_WIDTH-1:0]     fetch_pc,
    output logic                    ibuffer_instr_valid,
    input  logic                    ibuffer_instr_ready,
    output logic [INST_WIDTH-1:0]   ibuffer_inst_out,
    output logic [PC_WIDTH-1:0]     ibuffer_pc_out,
    output logic [$clog2(DEPTH):0]  ibuffer_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    ibuf_entry_t      mem [DEPTH];
    ibuf_entry_t      head;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign head   = mem[rd_idx];

    // Occupancy flags from registered pointers only
    always_comb begin
        empty = 1'b0;
        full  = 1'b0;
        if (wr_ptr == rd_ptr) begin
            empty = 1'b1;
        end
        if ((wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1])) begin
            full = 1'b1;
        end
    end

    // Handshakes; fetch_ready ignores a same-cycle dequeue to keep
    // ibuffer_instr_ready off the fetch timing path
    always_comb begin
        fetch_ready         = ~full;
        ibuffer_instr_valid = ~empty & ~flush;
        enq                 = fetch_valid & ~full & ~flush;
        deq                 = ~empty & ~flush & ibuffer_instr_ready;
    end

    // Head presentation, zeroed whenever nothing valid is offered
    always_comb begin
        ibuffer_inst_out = '0;
        ibuffer_pc_out   = '0;
        if (ibuffer_instr_valid) begin
            ibuffer_inst_out = INST_WIDTH'(head.inst);
            ibuffer_pc_out   = PC_WIDTH'(head.pc);
        end
    end

    // Occupancy is the pointer distance modulo 2*DEPTH
    always_comb begin
        ibuffer_count = PTR_W'(wr_ptr - rd_ptr);
    end

    // Entry storage; deliberately not reset
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_idx].inst <= IBUF_INST_W'(fetch_inst);
            mem[wr_idx].pc   <= IBUF_PC_W'(fetch_pc);
        end
    end

    ibuffer_ptr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (enq),
        .ptr     (wr_ptr)
    );

    ibuffer_ptr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (deq),
        .ptr     (rd_ptr)
    );

endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer using a queue scoreboard of accepted entries.
module tb_ibuffer;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [47:0] pc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic [47:0] fetch_pc;
    logic        ibuffer_instr_valid;
    logic        ibuffer_instr_ready;
    logic [31:0] ibuffer_inst_out;
    logic [47:0] ibuffer_pc_out;
    logic [3:0]  ibuffer_count;

    exp_t q[$];
    int   checks;
    int   failures;

    ibuffer dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .flush               (flush),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_inst          (fetch_inst),
        .fetch_pc            (fetch_pc),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_instr_ready (ibuffer_instr_ready),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out),
        .ibuffer_count       (ibuffer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic fv, input logic [31:0] inst, input logic [47:0] pc,
                         input logic rdy, input logic fl);
        fetch_valid         = fv;
        fetch_inst          = inst;
        fetch_pc            = pc;
        ibuffer_instr_ready = rdy;
        flush               = fl;
    endtask

    // Advance one clock edge, updating the scoreboard from the bench's own model
    task automatic tick();
        logic acc;
        logic dq;
        exp_t e;
        acc = fetch_valid && (q.size() < DEPTH) && !flush;
        dq  = (q.size() != 0) && !flush && ibuffer_instr_ready;
        e.inst = fetch_inst;
        e.pc   = fetch_pc;
        @(posedge clock);
        if (flush) begin
            q.delete();
        end else begin
            if (dq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 48'h0, 1'b0, 1'b0);
        #12;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ibuffer_instr_valid); end
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_fetch_ready got=%b exp=1", fetch_ready); end
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ibuffer_count); end
        reset_n = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", ibuffer_instr_valid); end
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL idle_fetch_ready got=%b exp=1", fetch_ready); end
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", ibuffer_count); end
        checks++; if (ibuffer_inst_out !== 32'h0) begin failures++; $display("FAIL idle_inst got=%h exp=0", ibuffer_inst_out); end
        checks++; if (ibuffer_pc_out !== 48'h0) begin failures++; $display("FAIL idle_pc got=%h exp=0", ibuffer_pc_out); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h0000_0013, 48'h8000_0000_0000, 1'b0, 1'b0);
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", ibuffer_instr_valid); end
        tick();
        drive(1'b0, 32'h0, 48'h0, 1'b0, 1'b0);
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ibuffer_instr_valid); end
        checks++; if (ibuffer_inst_out !== 32'h13) begin failures++; $display("FAIL single_inst got=%h exp=13", ibuffer_inst_out); end
        checks++; if (ibuffer_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", ibuffer_count); end
        tick();
        drive(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        #1;
        checks++; if (q.size() == 0 || ibuffer_pc_out !== q[0].pc) begin failures++; $display("FAIL single_pc got=%h exp=800000000000", ibuffer_pc_out); end
        tick();
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", ibuffer_instr_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), 48'h1000 + 48'(4 * i), 1'b0, 1'b0);
            #1;
            checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d got=%b exp=1", i, fetch_ready); end
            tick();
        end
        drive(1'b1, 32'hdead_beef, 48'h2000, 1'b0, 1'b0);
        #1;
        checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", fetch_ready); end
        checks++; if (ibuffer_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", ibuffer_count); end
        tick();
        // Offer while dequeuing at full: still refused
        drive(1'b1, 32'hdead_beef, 48'h2004, 1'b1, 1'b0);
        #1;
        checks++; if (ibuffer_count !== 4'd8) begin failures++; $display("FAIL full_9th_count got=%0d exp=8", ibuffer_count); end
        checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL full_deq_ready got=%b exp=0", fetch_ready); end
        checks++; if (ibuffer_pc_out !== 48'h1000) begin failures++; $display("FAIL drain_pc_0 got=%h exp=1000", ibuffer_pc_out); end
        tick();
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
            #1;
            checks++; if (ibuffer_instr_valid !== 1'b1) begin failures++; $display("FAIL drain_valid_%0d got=%b exp=1", i, ibuffer_instr_valid); end
            checks++; if (ibuffer_pc_out !== 48'h1000 + 48'(4 * i)) begin failures++; $display("FAIL drain_pc_%0d got=%h exp=%h", i, ibuffer_pc_out, 48'h1000 + 48'(4 * i)); end
            checks++; if (q.size() == 0 || ibuffer_inst_out !== q[0].inst) begin failures++; $display("FAIL drain_inst_%0d got=%h", i, ibuffer_inst_out); end
            tick();
        end
        drive(1'b0, 32'h0, 48'h0, 1'b0, 1'b0);
        #1;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", ibuffer_count); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 20; k++) begin
            drive(k < 20, 32'h100 + 32'(k), 48'h5000 + 48'(4 * k), 1'b1, 1'b0);
            #1;
            if (k > 0) begin
                checks++; if (ibuffer_count !== 4'd1) begin failures++; $display("FAIL stream_count_%0d got=%0d exp=1", k, ibuffer_count); end
                checks++; if (q.size() == 0 || ibuffer_pc_out !== q[0].pc || ibuffer_pc_out !== 48'h5000 + 48'(4 * (k - 1))) begin failures++; $display("FAIL stream_pc_%0d got=%h exp=%h", k, ibuffer_pc_out, 48'h5000 + 48'(4 * (k - 1))); end
            end
            tick();
        end
        #1;
        checks++; if (ibuffer_count !== 4'd0 || q.size() != 0) begin failures++; $display("FAIL stream_end_count got=%0d exp=0", ibuffer_count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 48'h6000 + 48'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h0bad_0bad, 48'hf00, 1'b1, 1'b1);
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ibuffer_instr_valid); end
        checks++; if (ibuffer_count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", ibuffer_count); end
        checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", fetch_ready); end
        tick();
        drive(1'b1, 32'h300, 48'h3000, 1'b0, 1'b0);
        #1;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", ibuffer_count); end
        tick();
        drive(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        #1;
        checks++; if (ibuffer_pc_out !== 48'h3000 || q.size() != 1) begin failures++; $display("FAIL flush_next_pc got=%h exp=3000", ibuffer_pc_out); end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 48'h7000 + 48'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 48'h0, 1'b0, 1'b0);
        #1;
        checks++; if (ibuffer_count !== 4'd3) begin failures++; $display("FAIL areset_pre_count got=%0d exp=3", ibuffer_count); end
        reset_n = 1'b0;
        q.delete();
        #1;
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", ibuffer_instr_valid); end
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", ibuffer_count); end
        checks++; if (ibuffer_pc_out !== 48'h0) begin failures++; $display("FAIL areset_pc got=%h exp=0", ibuffer_pc_out); end
        #2;
        reset_n = 1'b1;
        tick();
        drive(1'b1, 32'h55, 48'h4444, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        #1;
        checks++; if (ibuffer_count !== 4'd1) begin failures++; $display("FAIL areset_resume_count got=%0d exp=1", ibuffer_count); end
        checks++; if (ibuffer_pc_out !== 48'h4444 || q.size() == 0 || ibuffer_pc_out !== q[0].pc) begin failures++; $display("FAIL areset_resume_pc got=%h exp=4444", ibuffer_pc_out); end
        checks++; if (ibuffer_inst_out !== 32'h55) begin failures++; $display("FAIL areset_resume_inst got=%h exp=55", ibuffer_inst_out); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
